countdown_ctrl: RTL and testbench
=================================

Name: countdown_ctrl

Overview:
- Control and count core for the two-digit countdown timer.
- Upstream it takes the single-cycle pause/start and restart pulses produced by the onepulse button stages.
- It replaces the separate divider, counter and mode FSM with one clock domain, using a tick enable instead of a derived clock.
- Downstream it feeds BCD digits to the digit-extract/segment7/display chain and drives the LED bank.

Parameters:
TICK_DIV, 100000000, clk cycles per count tick (1 Hz at 100 MHz); legal range 2..2^27.
START_TENS, 3, reload value of the tens digit (0..9).
START_ONES, 0, reload value of the ones digit (0..9).

Ports:
clk  input  1  system clock, all state on the rising edge.
rst  input  1  asynchronous, active-low reset.
pause_pulse  input  1  one-cycle pulse from the pause button: start, pause or resume.
restart_pulse  input  1  one-cycle pulse from the restart button: reload and return to IDLE.
tens  output  4  BCD tens digit of the current count.
ones  output  4  BCD ones digit of the current count.
is_pause  output  1  high in PAUSE.
is_restart  output  1  high in IDLE.
done  output  1  high in DONE.
tick  output  1  one-cycle strobe on each count decrement (debug).
leds  output  16  status LED pattern.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; tens=START_TENS; ones=START_ONES.
  - prescaler=0; tick=0.
  - is_pause=0, is_restart=1, done=0, leds=16'h0000.
- States: IDLE, RUN, PAUSE, DONE; 2-bit register.
- Transitions, evaluated per rising edge in this priority:
  - restart_pulse from any state -> IDLE.
    - Reloads tens/ones to the START values and clears the prescaler in the same edge.
  - IDLE + pause_pulse -> RUN. If START is 00, goes directly -> DONE.
  - RUN + pause_pulse -> PAUSE.
  - PAUSE + pause_pulse -> RUN.
  - RUN + tick with count 01 -> DONE. The count becomes 00 on the same edge.
  - DONE + pause_pulse: ignored. Only restart leaves DONE.
- Prescaler (27-bit):
  - Increments only in RUN; holds its value in PAUSE, so a resume continues the partial period.
  - Cleared in IDLE and DONE.
  - tick is combinational: high when state=RUN and prescaler==TICK_DIV-1. The prescaler wraps to 0 on that cycle.
- BCD decrement on tick:
  - ones>0: ones-1.
  - ones=0: ones=9, tens=tens-1.
  - The count never goes below 00 and never wraps to 99.
- Simultaneous events:
  - restart_pulse with tick: restart wins and no decrement occurs.
  - pause_pulse with tick in RUN: the decrement is applied and state -> PAUSE.
  - pause_pulse with final tick (01->00): state -> DONE; the pause is dropped.
- Status outputs:
  - is_pause, is_restart and done are decoded directly from the state register. They change on the edge after the causing pulse.
  - leds decode from state: IDLE 16'h0000; RUN 16'h8000; PAUSE 16'h4000; DONE 16'hFFFF.
- Latency: a pulse sampled at edge N is visible on state and outputs after edge N.
- Out-of-range START digits (>9) are a configuration error: simulation $error at time 0, no RTL clamp.

Test Plan:
- TICK_DIV=4, START=12; reset asserted then released -> tens=1, ones=2, is_restart=1, leds=0000.
  - Then pause_pulse -> RUN, leds=8000.
  - ticks every 4 cycles; count 12->11->10->09.
- Continue the previous run to 01; at the next tick -> count 00, done=1, leds=FFFF, tick stops.
  - A pause_pulse in DONE leaves state DONE.
- RUN with prescaler=2, pause_pulse -> PAUSE, is_pause=1; hold 10 cycles with no count change.
  - Resume -> the next tick comes 1 cycle later, proving the prescaler was held.
- pause_pulse and restart_pulse asserted in the same cycle during RUN -> IDLE, count=12, prescaler=0, no tick.
  - Separately, restart_pulse coinciding with a tick -> count=12, not 11.
- START=00: IDLE + pause_pulse -> DONE in one edge, done=1, no tick.
  - Asserting rst mid-RUN at a non-clock time -> outputs return to their reset values immediately.

Source files
------------

// File: rtl/countdown_ctrl_if.sv
// Button-pulse inputs and display/status outputs of the countdown core.
// The master side is the button front end and the display chain; the slave side is countdown_ctrl.
interface countdown_ctrl_if;
  logic        pause_pulse;
  logic        restart_pulse;
  logic [3:0]  tens;
  logic [3:0]  ones;
  logic        is_pause;
  logic        is_restart;
  logic        done;
  logic        tick;
  logic [15:0] leds;

  modport master (
    output pause_pulse, restart_pulse,
    input  tens, ones, is_pause, is_restart, done, tick, leds
  );

  modport slave (
    input  pause_pulse, restart_pulse,
    output tens, ones, is_pause, is_restart, done, tick, leds
  );
endinterface

// File: rtl/countdown_ctrl.sv
// Two-digit BCD countdown core: mode FSM, tick prescaler and BCD counter in one clock domain.
// The count advances on a one-cycle tick enable rather than on a divided clock.
module countdown_ctrl #(
  parameter int TICK_DIV   = 100000000,
  parameter int START_TENS = 3,
  parameter int START_ONES = 0
) (
  input  logic             clk,
  input  logic             rst,
  countdown_ctrl_if.slave  bus
);

  localparam logic [26:0] PRESC_LAST = 27'(TICK_DIV - 1);
  localparam logic [3:0]  RL_TENS    = 4'(START_TENS);
  localparam logic [3:0]  RL_ONES    = 4'(START_ONES);
  localparam bit          START_ZERO = (START_TENS == 0) && (START_ONES == 0);

  if (START_TENS < 0 || START_TENS > 9 || START_ONES < 0 || START_ONES > 9) begin : g_bad_start
    $error("countdown_ctrl: START_TENS/START_ONES must be BCD digits 0..9");
  end
  if (TICK_DIV < 2 || TICK_DIV > 134217728) begin : g_bad_div
    $error("countdown_ctrl: TICK_DIV must be in 2..2^27");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, DONE = 2'd3} state_t;

  state_t      state, state_nxt;
  logic [3:0]  tens, tens_nxt;
  logic [3:0]  ones, ones_nxt;
  logic [26:0] presc, presc_nxt;
  logic        tick;
  logic [15:0] leds;

  assign tick = (state == RUN) && (presc == PRESC_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      tens  <= RL_TENS;
      ones  <= RL_ONES;
      presc <= '0;
    end else begin
      state <= state_nxt;
      tens  <= tens_nxt;
      ones  <= ones_nxt;
      presc <= presc_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tens_nxt  = tens;
    ones_nxt  = ones;
    presc_nxt = presc;
    if (bus.restart_pulse) begin
      // Restart outranks everything, including a tick landing on the same edge.
      state_nxt = IDLE;
      tens_nxt  = RL_TENS;
      ones_nxt  = RL_ONES;
      presc_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          presc_nxt = '0;
          if (bus.pause_pulse) state_nxt = START_ZERO ? DONE : RUN;
        end
        RUN: begin
          if (tick) begin
            presc_nxt = '0;
            if (ones != 4'd0) begin
              ones_nxt = ones - 4'd1;
            end else if (tens != 4'd0) begin
              ones_nxt = 4'd9;
              tens_nxt = tens - 4'd1;
            end
            // Reaching 00 swallows a coincident pause.
            if (tens == 4'd0 && ones == 4'd1) state_nxt = DONE;
            else if (bus.pause_pulse)         state_nxt = PAUSE;
          end else begin
            presc_nxt = presc + 27'd1;
            if (bus.pause_pulse) state_nxt = PAUSE;
          end
        end
        // Prescaler holds here so a resume finishes the partial period.
        PAUSE: if (bus.pause_pulse) state_nxt = RUN;
        DONE:  presc_nxt = '0;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    leds = 16'h0000;
    case (state)
      RUN:     leds = 16'h8000;
      PAUSE:   leds = 16'h4000;
      DONE:    leds = 16'hFFFF;
      default: leds = 16'h0000;
    endcase
  end

  assign bus.tens       = tens;
  assign bus.ones       = ones;
  assign bus.is_pause   = (state == PAUSE);
  assign bus.is_restart = (state == IDLE);
  assign bus.done       = (state == DONE);
  assign bus.tick       = tick;
  assign bus.leds       = leds;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Bench for countdown_ctrl: directed literal checks plus random pulses against an integer-count model.
module tb_countdown_ctrl;

  localparam int DIV_A = 4, START_A = 12;
  localparam int DIV_B = 3, START_B = 0;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  typedef struct packed { int mode; int cnt; int ph; } mst_t;

  logic clk, rst_a, rst_b;
  int   n_cmp, n_bad;
  mst_t ms_a, ms_b;

  countdown_ctrl_if ifa ();
  countdown_ctrl_if ifb ();

  countdown_ctrl #(.TICK_DIV(DIV_A), .START_TENS(1), .START_ONES(2)) dut_a (
    .clk(clk), .rst(rst_a), .bus(ifa.slave));
  countdown_ctrl #(.TICK_DIV(DIV_B), .START_TENS(0), .START_ONES(0)) dut_b (
    .clk(clk), .rst(rst_b), .bus(ifb.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: count held as a plain integer, tick period as a phase counter.
  function automatic mst_t step(input mst_t s, input int div, input int start,
                                input logic pp, input logic rp);
    mst_t n;
    bit   tk;
    n  = s;
    tk = (s.mode == M_RUN) && (s.ph == div - 1);
    if (rp) begin
      n.mode = M_IDLE; n.cnt = start; n.ph = 0;
    end else begin
      case (s.mode)
        M_IDLE:  if (pp) n.mode = (start == 0) ? M_DONE : M_RUN;
        M_RUN: begin
          if (tk) begin
            n.ph  = 0;
            n.cnt = s.cnt - 1;
            if (n.cnt == 0) n.mode = M_DONE;
            else if (pp)    n.mode = M_PAUSE;
          end else begin
            n.ph = s.ph + 1;
            if (pp) n.mode = M_PAUSE;
          end
        end
        M_PAUSE: if (pp) n.mode = M_RUN;
        default: ;
      endcase
    end
    return n;
  endfunction

  function automatic mst_t reset_state(input int start);
    mst_t r;
    r.mode = M_IDLE; r.cnt = start; r.ph = 0;
    return r;
  endfunction

  always @(posedge clk or negedge rst_a)
    if (!rst_a) ms_a <= reset_state(START_A);
    else        ms_a <= step(ms_a, DIV_A, START_A, ifa.pause_pulse, ifa.restart_pulse);

  always @(posedge clk or negedge rst_b)
    if (!rst_b) ms_b <= reset_state(START_B);
    else        ms_b <= step(ms_b, DIV_B, START_B, ifb.pause_pulse, ifb.restart_pulse);

  task automatic cmp(input string nm, input mst_t s, input int div,
                     input logic [3:0] t, input logic [3:0] o, input logic ip,
                     input logic ir, input logic dn, input logic tk, input logic [15:0] ld);
    logic [27:0] act, exp;
    logic [15:0] el;
    case (s.mode)
      M_RUN:   el = 16'h8000;
      M_PAUSE: el = 16'h4000;
      M_DONE:  el = 16'hFFFF;
      default: el = 16'h0000;
    endcase
    act = {t, o, ip, ir, dn, tk, ld};
    exp = {4'(s.cnt / 10), 4'(s.cnt % 10), s.mode == M_PAUSE, s.mode == M_IDLE,
           s.mode == M_DONE, (s.mode == M_RUN) && (s.ph == div - 1), el};
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got {tens,ones,p,r,d,t,leds}=%h expected %h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    cmp("model_a", ms_a, DIV_A, ifa.tens, ifa.ones, ifa.is_pause, ifa.is_restart,
        ifa.done, ifa.tick, ifa.leds);
    cmp("model_b", ms_b, DIV_B, ifb.tens, ifb.ones, ifb.is_pause, ifb.is_restart,
        ifb.done, ifb.tick, ifb.leds);
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d (0x%0h) expected %0d (0x%0h)", nm, $time, act, act, exp, exp);
    end
  endtask

  task automatic pulse_a(input bit p, input bit r);
    ifa.pause_pulse = p; ifa.restart_pulse = r;
    @(posedge clk); #1;
    ifa.pause_pulse = 1'b0; ifa.restart_pulse = 1'b0;
  endtask

  task automatic pulse_b(input bit p, input bit r);
    ifb.pause_pulse = p; ifb.restart_pulse = r;
    @(posedge clk); #1;
    ifb.pause_pulse = 1'b0; ifb.restart_pulse = 1'b0;
  endtask

  // Negedges until dut_a shows tick, bounded.
  task automatic gap_a(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ifa.tick && n < 20);
    if (!ifa.tick) chk("tick_timeout", 0, 1);
  endtask

  function automatic int cnt_a();
    return 10 * int'(ifa.tens) + int'(ifa.ones);
  endfunction

  initial begin
    int n;
    n_cmp = 0; n_bad = 0;
    rst_a = 1'b0; rst_b = 1'b0;
    ifa.pause_pulse = 1'b0; ifa.restart_pulse = 1'b0;
    ifb.pause_pulse = 1'b0; ifb.restart_pulse = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_a = 1'b1; rst_b = 1'b1;

    @(negedge clk);
    chk("rst_count", cnt_a(), 12);
    chk("rst_is_restart", int'(ifa.is_restart), 1);
    chk("rst_leds", int'(ifa.leds), 16'h0000);
    chk("rst_done", int'(ifa.done), 0);

    #1 pulse_a(1, 0);
    @(negedge clk);
    chk("run_leds", int'(ifa.leds), 16'h8000);
    chk("run_is_restart", int'(ifa.is_restart), 0);
    gap_a(n);
    chk("first_gap", n, 3);
    chk("cnt_at_tick12", cnt_a(), 12);
    for (int c = 11; c >= 1; c--) begin
      gap_a(n);
      chk("tick_gap", n, 4);
      chk("cnt_at_tick", cnt_a(), c);
    end
    @(negedge clk);
    chk("final_cnt", cnt_a(), 0);
    chk("final_done", int'(ifa.done), 1);
    chk("final_leds", int'(ifa.leds), 16'hFFFF);
    chk("final_tick", int'(ifa.tick), 0);
    #1 pulse_a(1, 0);
    @(negedge clk);
    chk("done_ignores_pause", int'(ifa.done), 1);
    chk("done_cnt_held", cnt_a(), 0);

    // Pause with the prescaler part-way through a period.
    #1 pulse_a(0, 1);
    @(negedge clk);
    chk("restart_idle", int'(ifa.is_restart), 1);
    chk("restart_cnt", cnt_a(), 12);
    #1 pulse_a(1, 0);
    repeat (3) @(negedge clk);
    #1 pulse_a(1, 0);
    repeat (10) begin
      @(negedge clk);
      chk("pause_flag", int'(ifa.is_pause), 1);
      chk("pause_cnt", cnt_a(), 12);
      chk("pause_leds", int'(ifa.leds), 16'h4000);
    end
    #1 pulse_a(1, 0);
    gap_a(n);
    chk("resume_gap", n, 1);
    @(negedge clk);
    chk("resume_cnt", cnt_a(), 11);

    #1 pulse_a(1, 1);
    @(negedge clk);
    chk("both_idle", int'(ifa.is_restart), 1);
    chk("both_cnt", cnt_a(), 12);
    chk("both_tick", int'(ifa.tick), 0);

    #1 pulse_a(1, 0);
    gap_a(n);
    chk("pre_restart_gap", n, 4);
    #1 pulse_a(0, 1);
    @(negedge clk);
    chk("restart_on_tick_cnt", cnt_a(), 12);
    chk("restart_on_tick_idle", int'(ifa.is_restart), 1);

    #1 pulse_b(1, 0);
    @(negedge clk);
    chk("zero_done", int'(ifb.done), 1);
    chk("zero_tick", int'(ifb.tick), 0);
    chk("zero_leds", int'(ifb.leds), 16'hFFFF);
    chk("zero_cnt", 10 * int'(ifb.tens) + int'(ifb.ones), 0);

    // Asynchronous reset landing between clock edges.
    #1 pulse_a(1, 0);
    gap_a(n);
    repeat (2) @(negedge clk);
    chk("pre_arst_cnt", cnt_a(), 11);
    @(posedge clk);
    #2 rst_a = 1'b0;
    #1;
    chk("arst_cnt", cnt_a(), 12);
    chk("arst_leds", int'(ifa.leds), 16'h0000);
    chk("arst_is_restart", int'(ifa.is_restart), 1);
    chk("arst_tick", int'(ifa.tick), 0);
    @(negedge clk);
    #1 rst_a = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      #1;
      ifa.pause_pulse   = ($urandom_range(0, 5) == 0);
      ifa.restart_pulse = ($urandom_range(0, 79) == 0);
      ifb.pause_pulse   = ($urandom_range(0, 3) == 0);
      ifb.restart_pulse = ($urandom_range(0, 9) == 0);
      rst_a = ($urandom_range(0, 499) != 0);
      rst_b = ($urandom_range(0, 199) != 0);
    end
    @(negedge clk);
    #1;
    ifa.pause_pulse = 1'b0; ifa.restart_pulse = 1'b0;
    ifb.pause_pulse = 1'b0; ifb.restart_pulse = 1'b0;
    rst_a = 1'b1; rst_b = 1'b1;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
